// File: rtl/data_mem_ctrl.sv
// Data-side memory: 64-bit byte-lane RAM plus MMIO window (debug byte FIFO, STATUS, CYCLE); loads are combinational, stores commit at the clock edge.
// Debug FIFO drains over dbg_valid/dbg_ready and drops pushes that hit a full FIFO with no pop (sticky overflow); `define DMEM_CYCLE_CNT_EN builds the CYCLE counter.
module data_mem_ctrl #(
  parameter int          DEPTH_WORDS = 512,
  parameter logic [31:0] MMIO_BASE   = 32'h0000_F000,
  parameter int          FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        wr_en,
  input  logic [63:0] wdata,
  input  logic [7:0]  wmask,
  output logic [63:0] rdata,
  output logic        dbg_valid,
  output logic [7:0]  dbg_data,
  input  logic        dbg_ready
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam int          PW        = $clog2(FIFO_DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS) << 3;
  localparam logic [31:0] MMIO_LAST = MMIO_BASE + 32'h0000_0FFF;
  localparam logic [8:0]  OFF_TX     = 9'd0;
  localparam logic [8:0]  OFF_STATUS = 9'd1;
  localparam logic [8:0]  OFF_CYCLE  = 9'd2;
  localparam logic [PW:0] CNT_FULL   = (PW+1)'(FIFO_DEPTH);

  logic          sel_ram;
  logic          sel_mmio;
  logic [AW-1:0] ram_idx;
  logic [8:0]    mmio_off;

  assign sel_ram  = (addr < MMIO_BASE) && (addr < RAM_BYTES);
  assign sel_mmio = (addr >= MMIO_BASE) && (addr <= MMIO_LAST);
  assign ram_idx  = addr[3 +: AW];
  assign mmio_off = 9'((addr - MMIO_BASE) >> 3);

  logic [63:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (!rst && wr_en && sel_ram) begin
      for (int i = 0; i < 8; i++) begin
        if (wmask[i]) mem[ram_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;
  logic          overflow;
  logic          fifo_full;
  logic          pop;
  logic          push_req;
  logic          push_ok;
  logic          ovf_clr;

  assign fifo_full = (count == CNT_FULL);
  assign dbg_valid = (count != '0);
  assign dbg_data  = dbg_valid ? fifo_mem[rd_ptr] : 8'h00;
  assign pop       = dbg_valid & dbg_ready;
  assign push_req  = wr_en & sel_mmio & (mmio_off == OFF_TX) & wmask[0];
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push_ok   = push_req & (~fifo_full | pop);
  assign ovf_clr   = wr_en & sel_mmio & (mmio_off == OFF_STATUS) & wmask[0] & wdata[2];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A new overflow wins over a same-cycle clear.
      overflow <= (overflow & ~ovf_clr) | (push_req & ~push_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_ok) fifo_mem[wr_ptr] <= wdata[7:0];
  end

  logic [63:0] cycle_val;

`ifdef DMEM_CYCLE_CNT_EN
  logic [63:0] cycle_cnt;

  always_ff @(posedge clk) begin
    if (rst) cycle_cnt <= '0;
    else     cycle_cnt <= cycle_cnt + 64'd1;
  end

  assign cycle_val = cycle_cnt;
`else
  assign cycle_val = '0;
`endif

  always_comb begin
    rdata = '0;
    if (sel_ram) begin
      rdata = mem[ram_idx];
    end else if (sel_mmio) begin
      case (mmio_off)
        OFF_STATUS: rdata = {48'h0, 8'(count), 5'h0, overflow, fifo_full, ~dbg_valid};
        OFF_CYCLE:  rdata = cycle_val;
        default:    rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboarded random bench for data_mem_ctrl against a queue/array reference model.
`timescale 1ns/1ps
module tb_data_mem_ctrl;

  localparam int          DEPTH_WORDS = 512;
  localparam logic [31:0] MMIO_BASE   = 32'h0000_F000;
  localparam int          FD          = 8;
  localparam logic [31:0] A_TX = MMIO_BASE;
  localparam logic [31:0] A_ST = MMIO_BASE + 32'h8;
  localparam logic [31:0] A_CY = MMIO_BASE + 32'h10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic        wr_en = 1'b0;
  logic [63:0] wdata = '0;
  logic [7:0]  wmask = '0;
  logic [63:0] rdata;
  logic        dbg_valid;
  logic [7:0]  dbg_data;
  logic        dbg_ready = 1'b0;

  always #5 clk = ~clk;

  data_mem_ctrl #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .MMIO_BASE  (MMIO_BASE),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .wr_en    (wr_en),
    .wdata    (wdata),
    .wmask    (wmask),
    .rdata    (rdata),
    .dbg_valid(dbg_valid),
    .dbg_data (dbg_data),
    .dbg_ready(dbg_ready)
  );

  // Reference model state
  logic [63:0] mram [DEPTH_WORDS];
  int          mcount = 0;
  logic        movf = 1'b0;
  logic [63:0] mcyc = '0;
  logic [7:0]  exp_dbg [$];
  logic [63:0] exp_rd [$];

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;
  bit chk_rd = 1'b0;

  function automatic int mmio_slot(input logic [31:0] a);
    if (a >= MMIO_BASE && a <= MMIO_BASE + 32'hFFF) return int'((a - MMIO_BASE) >> 3);
    return -1;
  endfunction

  function automatic logic [63:0] model_read(input logic [31:0] a);
    int s;
    if (a < MMIO_BASE) return (a < DEPTH_WORDS * 8) ? mram[int'(a >> 3)] : 64'h0;
    s = mmio_slot(a);
    if (s == 1) return {48'h0, 8'(mcount), 5'h0, movf, (mcount == FD), (mcount == 0)};
`ifdef DMEM_CYCLE_CNT_EN
    if (s == 2) return mcyc;
`endif
    return 64'h0;
  endfunction

  int slot;
  bit pre_pop;
  bit push_req;

  always @(posedge clk) begin
    if (rst) begin
      exp_dbg.delete();
      mcount = 0;
      movf   = 1'b0;
      mcyc   = '0;
    end else begin
      mcyc     = mcyc + 64'd1;
      pre_pop  = (mcount != 0) && dbg_ready;
      slot     = mmio_slot(addr);
      push_req = wr_en && (slot == 0) && wmask[0];
      if (wr_en && addr < MMIO_BASE && addr < DEPTH_WORDS * 8) begin
        for (int i = 0; i < 8; i++)
          if (wmask[i]) mram[int'(addr >> 3)][8*i +: 8] = wdata[8*i +: 8];
      end
      if (wr_en && slot == 1 && wmask[0] && wdata[2]) movf = 1'b0;
      if (pre_pop) mcount = mcount - 1;
      if (push_req) begin
        if (mcount < FD) begin
          exp_dbg.push_back(wdata[7:0]);
          mcount = mcount + 1;
        end else begin
          movf = 1'b1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard queues.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("dbg_valid", {63'h0, dbg_valid}, {63'h0, (mcount != 0)});
      if (dbg_valid && dbg_ready) begin
        if (exp_dbg.size() == 0) chk("dbg_unexpected_pop", {56'h0, dbg_data}, 64'hXX);
        else chk("dbg_data", {56'h0, dbg_data}, {56'h0, exp_dbg.pop_front()});
      end else if (!dbg_valid) begin
        chk("dbg_data_idle", {56'h0, dbg_data}, 64'h0);
      end
      if (chk_rd) begin
        if (exp_rd.size() == 0) chk("rdata_no_expect", rdata, 64'hXX);
        else chk("rdata", rdata, exp_rd.pop_front());
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [63:0] d, input logic [7:0] m);
    addr = a; wdata = d; wmask = m; wr_en = 1'b1;
    tick();
    wr_en = 1'b0; wmask = '0;
  endtask

  task automatic load_exp(input logic [31:0] a, input logic [63:0] v);
    addr = a;
    exp_rd.push_back(v);
    chk_rd = 1'b1;
    tick();
    chk_rd = 1'b0;
  endtask

  task automatic load(input logic [31:0] a);
    load_exp(a, model_read(a));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, time %0t required below 1000000", $time);
    $fatal(1);
  end

  initial begin
    logic [63:0] cyc_exp;
    repeat (3) tick();
    mon_en = 1'b1;
    rst = 1'b0;
    load_exp(A_ST, 64'h1);

    for (int i = 0; i < DEPTH_WORDS; i++) store(32'(i * 8), {$urandom, $urandom}, 8'hFF);

    // Byte-lane write
    store(32'h40, 64'h1122334455667788, 8'hFF);
    store(32'h40, 64'hAABBCCDDEEFF11EE, 8'h01);
    load_exp(32'h40, 64'h11223344556677EE);
    load_exp(32'h45, 64'h11223344556677EE);

    // Out of range / above window
    load_exp(32'h1000, 64'h0);
    store(32'h1000, 64'hDEADBEEFDEADBEEF, 8'hFF);
    load(32'h0); load(32'h40); load(32'hFF8);
    load_exp(32'h0001_0000, 64'h0);
    store(32'h0001_0000, 64'h0123456789ABCDEF, 8'hFF);
    load(32'h0); load(32'hFF8);
    load_exp(A_TX, 64'h0);

    // Fill, overflow, drain
    dbg_ready = 1'b0;
    for (int b = 1; b <= 9; b++) store(A_TX, 64'(b), 8'h01);
    load_exp(A_ST, 64'h0806);
    dbg_ready = 1'b1;
    repeat (10) tick();
    load_exp(A_ST, 64'h0005);
    store(A_ST, 64'h4, 8'h01);
    load_exp(A_ST, 64'h0001);

    // Full push + pop
    dbg_ready = 1'b0;
    for (int b = 0; b < 8; b++) store(A_TX, 64'(8'h10 + b), 8'h01);
    dbg_ready = 1'b1;
    store(A_TX, 64'hA5, 8'h01);
    dbg_ready = 1'b0;
    load_exp(A_ST, 64'h0802);
    dbg_ready = 1'b1;
    repeat (10) tick();
    store(A_TX, 64'h77, 8'hFE);
    load_exp(A_ST, 64'h0001);

    // Randomized mix
    for (int n = 0; n < 400; n++) begin
      dbg_ready = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 6))
        0: store($urandom_range(0, 32'h1FFF), {$urandom, $urandom}, 8'($urandom));
        1: store(A_TX + $urandom_range(0, 7), {$urandom, $urandom}, 8'($urandom));
        2: store(A_ST + $urandom_range(0, 7), 64'($urandom_range(0, 7)), 8'($urandom_range(0, 3)));
        3: load($urandom_range(0, 32'h1FFF));
        4: load(MMIO_BASE + $urandom_range(0, 32'h1F));
        5: load($urandom);
        default: tick();
      endcase
    end

    // Reset mid-drain with a store in the reset cycle
    dbg_ready = 1'b0;
    for (int b = 0; b < 5; b++) store(A_TX, 64'(8'hC0 + b), 8'h01);
    dbg_ready = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
    store(32'h80, 64'hFFFF_0000_FFFF_0000, 8'hFF);
    rst = 1'b0;
    repeat (5) tick();
`ifdef DMEM_CYCLE_CNT_EN
    cyc_exp = 64'd5;
`else
    cyc_exp = 64'd0;
`endif
    load_exp(A_CY, cyc_exp);
    load(32'h80);
    load_exp(A_ST, 64'h0001);

    repeat (2) tick();
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
